// File: rtl/pulse_width_detector.sv
// Measures high pulses on an asynchronous line and reports width plus a SHORT/MID/LONG/TIMEOUT class.
// Latency: report strobe one cycle after the synchronised line is first seen low (SYNC_STAGES + 1 from pin sample).
// Backpressure: none; width_valid and glitch are single-cycle strobes that the consumer must take when they fire.
module pulse_width_detector #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WIDTH   = 2,
    parameter int SHORT_MAX   = 12,
    parameter int MID_MAX     = 37,
    parameter int MAX_WIDTH   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pulse_in,
    output logic             width_valid,
    output logic [CNT_W-1:0] width,
    output logic [1:0]       width_class,
    output logic             glitch,
    output logic [7:0]       glitch_cnt,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] SHORT_W = CNT_W'(SHORT_MAX);
    localparam logic [CNT_W-1:0] MID_W   = CNT_W'(MID_MAX);
    localparam logic [CNT_W-1:0] MAX_W   = CNT_W'(MAX_WIDTH);

    typedef enum logic [1:0] {
        ARM      = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               rpt_vld;
    logic [CNT_W-1:0]   rpt_width;
    logic [1:0]         rpt_class;
    logic               glitch_nxt;

    // Synchroniser is deliberately left out of reset so a line held high through reset is seen high on release.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge clk) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rpt_vld    = 1'b0;
        rpt_width  = cnt;
        rpt_class  = 2'd0;
        glitch_nxt = 1'b0;
        case (state)
            ARM: begin
                if (!s) state_nxt = IDLE;
            end
            IDLE: begin
                if (s) begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (s) begin
                    if (cnt < MAX_W) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end else begin
                        rpt_vld   = 1'b1;
                        rpt_width = MAX_W;
                        rpt_class = 2'd3;
                        state_nxt = WAIT_LOW;
                    end
                end else if (cnt >= MIN_W) begin
                    rpt_vld   = 1'b1;
                    rpt_class = (cnt <= SHORT_W) ? 2'd0 : (cnt <= MID_W) ? 2'd1 : 2'd2;
                    state_nxt = IDLE;
                end else begin
                    glitch_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!s) state_nxt = IDLE;
            end
            default: state_nxt = ARM;
        endcase
        // Disabling abandons any pulse in flight silently and forces a fresh low before re-arming.
        if (!enable) begin
            state_nxt  = ARM;
            rpt_vld    = 1'b0;
            glitch_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARM;
            cnt         <= '0;
            width_valid <= 1'b0;
            width       <= '0;
            width_class <= 2'd0;
            glitch      <= 1'b0;
            glitch_cnt  <= 8'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            width_valid <= rpt_vld;
            glitch      <= glitch_nxt;
            if (rpt_vld) begin
                width       <= rpt_width;
                width_class <= rpt_class;
            end
            if (glitch_nxt && glitch_cnt != 8'hFF) begin
                glitch_cnt <= glitch_cnt + 8'd1;
            end
        end
    end

    assign busy = (state == HIGH);

endmodule
